// File: rtl/mem_arb_pkg.sv
// Shared constants and helpers for the bank-to-memory arbiter.
// The bank ID is stamped into the low bits of the 8-bit opaque field.
package mem_arb_pkg;

  localparam int unsigned OPAQUE_NBITS            = 8;
  localparam int unsigned DEFAULT_REQ_OPAQUE_LSB  = 166;
  localparam int unsigned DEFAULT_RESP_OPAQUE_LSB = 134;

  typedef logic [OPAQUE_NBITS-1:0] opaque_t;

  // Number of opaque bits replaced by the bank ID (0 for a single bank).
  function automatic int unsigned bank_id_nbits(input int unsigned num_banks);
    return (num_banks > 1) ? $clog2(num_banks) : 0;
  endfunction

  // Width of an index/pointer register; never zero so it can be declared.
  function automatic int unsigned bank_idx_nbits(input int unsigned num_banks);
    return (num_banks > 1) ? $clog2(num_banks) : 1;
  endfunction

  function automatic opaque_t bank_id_mask(input int unsigned num_banks);
    return OPAQUE_NBITS'((1 << bank_id_nbits(num_banks)) - 1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: scans from rr_ptr upward with wrap-around, and
// moves the pointer to one past the winner only when en (a fire) is high.
module rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned p_n = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [p_n-1:0] req,
  input  logic           en,
  output logic [p_n-1:0] grant
);

  localparam int unsigned PTR_NBITS = bank_idx_nbits(p_n);

  logic [PTR_NBITS-1:0] rr_ptr_reg;
  logic [PTR_NBITS-1:0] rr_ptr_next;
  logic [PTR_NBITS-1:0] grant_idx;
  logic [PTR_NBITS-1:0] cand;
  logic                 found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    cand      = '0;
    found     = 1'b0;
    for (int unsigned k = 0; k < p_n; k++) begin
      cand = PTR_NBITS'((32'(rr_ptr_reg) + k) % p_n);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    rr_ptr_next = rr_ptr_reg;
    if (en && found) begin
      rr_ptr_next = PTR_NBITS'((32'(grant_idx) + 1) % p_n);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_reg <= '0;
    end else begin
      rr_ptr_reg <= rr_ptr_next;
    end
  end

endmodule

// File: rtl/mem_bank_arbiter.sv
// Merges N blocking cache-bank request streams onto one memory port and
// routes responses back by the bank ID stamped into the opaque field.
module mem_bank_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned p_num_banks       = 4,
  parameter int unsigned p_req_nbits       = 175,
  parameter int unsigned p_resp_nbits      = 145,
  parameter int unsigned p_req_opaque_lsb  = DEFAULT_REQ_OPAQUE_LSB,
  parameter int unsigned p_resp_opaque_lsb = DEFAULT_RESP_OPAQUE_LSB
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [p_num_banks-1:0]              bank_req_val,
  output logic [p_num_banks-1:0]              bank_req_rdy,
  input  logic [p_num_banks*p_req_nbits-1:0]  bank_req_msg,
  output logic [p_num_banks-1:0]              bank_resp_val,
  input  logic [p_num_banks-1:0]              bank_resp_rdy,
  output logic [p_num_banks*p_resp_nbits-1:0] bank_resp_msg,
  output logic                                memreq_val,
  input  logic                                memreq_rdy,
  output logic [p_req_nbits-1:0]              memreq_msg,
  input  logic                                memresp_val,
  output logic                                memresp_rdy,
  input  logic [p_resp_nbits-1:0]             memresp_msg,
  output logic                                route_err
);

  localparam int unsigned IDX_NBITS = bank_idx_nbits(p_num_banks);
  localparam opaque_t     ID_MASK   = bank_id_mask(p_num_banks);

  logic [p_num_banks-1:0]  outstanding_reg;
  logic [p_num_banks-1:0]  outstanding_next;
  opaque_t                 saved_opaque_reg [p_num_banks];
  logic                    route_err_reg;

  logic [p_req_nbits-1:0]  req_msg_arr [p_num_banks];
  logic [p_num_banks-1:0]  elig;
  logic [p_num_banks-1:0]  grant;
  logic [IDX_NBITS-1:0]    grant_idx;
  opaque_t                 req_opaque;
  logic                    req_fire;

  logic [IDX_NBITS-1:0]    resp_idx;
  logic                    route_ok;
  logic                    resp_fire;
  logic [p_resp_nbits-1:0] resp_msg_restored;

  genvar gi;
  generate
    for (gi = 0; gi < p_num_banks; gi++) begin : g_bank
      assign req_msg_arr[gi] = bank_req_msg[gi*p_req_nbits +: p_req_nbits];
      assign bank_resp_msg[gi*p_resp_nbits +: p_resp_nbits] = resp_msg_restored;
    end
  endgenerate

  // A bank with a transaction in flight is ineligible, even in the cycle
  // its response fires.
  assign elig = bank_req_val & ~outstanding_reg;

  rr_arbiter #(
    .p_n (p_num_banks)
  ) u_rr_arbiter (
    .clk   (clk),
    .reset (reset),
    .req   (elig),
    .en    (req_fire),
    .grant (grant)
  );

  always_comb begin
    grant_idx = '0;
    for (int unsigned i = 0; i < p_num_banks; i++) begin
      if (grant[i]) grant_idx = IDX_NBITS'(i);
    end
  end

  assign memreq_val   = ~reset & (|elig);
  assign req_fire     = memreq_val & memreq_rdy;
  assign bank_req_rdy = {p_num_banks{~reset & memreq_rdy}} & grant;
  assign req_opaque   = req_msg_arr[grant_idx][p_req_opaque_lsb +: OPAQUE_NBITS];

  always_comb begin
    memreq_msg = req_msg_arr[grant_idx];
    memreq_msg[p_req_opaque_lsb +: OPAQUE_NBITS] =
      (req_opaque & ~ID_MASK) | (OPAQUE_NBITS'(grant_idx) & ID_MASK);
  end

  // Masking keeps the index below N for every legal (power-of-two) N.
  assign resp_idx  = IDX_NBITS'(memresp_msg[p_resp_opaque_lsb +: OPAQUE_NBITS] & ID_MASK);
  assign route_ok  = outstanding_reg[resp_idx];
  assign memresp_rdy = ~reset & (route_ok ? bank_resp_rdy[resp_idx] : 1'b1);
  assign resp_fire = memresp_val & memresp_rdy;

  always_comb begin
    bank_resp_val = '0;
    if (!reset && memresp_val && route_ok) begin
      bank_resp_val[resp_idx] = 1'b1;
    end
  end

  always_comb begin
    resp_msg_restored = memresp_msg;
    resp_msg_restored[p_resp_opaque_lsb +: OPAQUE_NBITS] = saved_opaque_reg[resp_idx];
  end

  always_comb begin
    outstanding_next = outstanding_reg;
    if (req_fire) outstanding_next[grant_idx] = 1'b1;
    if (resp_fire && route_ok) outstanding_next[resp_idx] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      outstanding_reg <= '0;
      route_err_reg   <= 1'b0;
      for (int unsigned i = 0; i < p_num_banks; i++) begin
        saved_opaque_reg[i] <= '0;
      end
    end else begin
      outstanding_reg <= outstanding_next;
      if (req_fire) saved_opaque_reg[grant_idx] <= req_opaque;
      if (resp_fire && !route_ok) route_err_reg <= 1'b1;
    end
  end

  assign route_err = route_err_reg;

endmodule
